// File: rtl/mem_rr_arbiter_if.sv
// Single-port memory command/response bus between the arbiter (master) and the memory (slave).
interface mem_rr_arbiter_if #(
    parameter int WIDTH      = 2,
    parameter int ADDR_WIDTH = 3
);
    logic                  valid;
    logic                  wr_rd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      wr_data;
    logic                  ready;
    logic [WIDTH-1:0]      rd_data;

    modport master (
        output valid, wr_rd, addr, wr_data,
        input  ready, rd_data
    );

    modport slave (
        input  valid, wr_rd, addr, wr_data,
        output ready, rd_data
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port valid/ready memory.
// Grant to done takes 2 cycles (3-cycle throughput); a losing requester simply waits, and a watchdog ends stalled accesses with err.
module mem_rr_arbiter #(
    parameter int WIDTH      = 2,
    parameter int ADDR_WIDTH = 3,
    parameter int TIMEOUT    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid_i,
    input  logic                  req0_wr_rd_i,
    input  logic [ADDR_WIDTH-1:0] req0_addr_i,
    input  logic [WIDTH-1:0]      req0_wr_data_i,
    input  logic                  req1_valid_i,
    input  logic                  req1_wr_rd_i,
    input  logic [ADDR_WIDTH-1:0] req1_addr_i,
    input  logic [WIDTH-1:0]      req1_wr_data_i,
    output logic                  req0_gnt_o,
    output logic                  req0_done_o,
    output logic [WIDTH-1:0]      req0_rd_data_o,
    output logic                  req1_gnt_o,
    output logic                  req1_done_o,
    output logic [WIDTH-1:0]      req1_rd_data_o,
    output logic                  err_o,
    mem_rr_arbiter_if.master      mem
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    state_t                     state_q;
    logic                       owner_q;
    logic                       last_q;
    logic [7:0]                 wdog_q;
    logic [1:0]                 gnt_q;
    logic [1:0]                 done_q;
    logic                       err_q;
    logic [1:0][WIDTH-1:0]      rd_q;
    logic                       mem_valid_q;
    logic                       mem_wr_rd_q;
    logic [ADDR_WIDTH-1:0]      mem_addr_q;
    logic [WIDTH-1:0]           mem_wr_data_q;

    logic any_vld;
    logic win_d;

    assign any_vld = req0_valid_i | req1_valid_i;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        win_d = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            win_d = ~last_q;
        end else if (req1_valid_i) begin
            win_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= 1'b0;
            last_q        <= 1'b1;
            wdog_q        <= '0;
            gnt_q         <= '0;
            done_q        <= '0;
            err_q         <= 1'b0;
            rd_q          <= '0;
            mem_valid_q   <= 1'b0;
            mem_wr_rd_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_vld) begin
                        owner_q        <= win_d;
                        gnt_q[win_d]   <= 1'b1;
                        mem_valid_q    <= 1'b1;
                        mem_wr_rd_q    <= win_d ? req1_wr_rd_i   : req0_wr_rd_i;
                        mem_addr_q     <= win_d ? req1_addr_i    : req0_addr_i;
                        mem_wr_data_q  <= win_d ? req1_wr_data_i : req0_wr_data_i;
                        state_q        <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_valid_q <= 1'b0;
                    wdog_q      <= '0;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    if (mem.ready) begin
                        if (!mem_wr_rd_q) begin
                            rd_q[owner_q] <= mem.rd_data;
                        end
                        done_q[owner_q] <= 1'b1;
                        last_q          <= owner_q;
                        state_q         <= IDLE;
                    end else if (wdog_q == WDOG_LAST) begin
                        // Stalled access: complete with error, read data left untouched.
                        done_q[owner_q] <= 1'b1;
                        err_q           <= 1'b1;
                        last_q          <= owner_q;
                        state_q         <= IDLE;
                    end else begin
                        wdog_q <= wdog_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req0_gnt_o     = gnt_q[0];
    assign req1_gnt_o     = gnt_q[1];
    assign req0_done_o    = done_q[0];
    assign req1_done_o    = done_q[1];
    assign req0_rd_data_o = rd_q[0];
    assign req1_rd_data_o = rd_q[1];
    assign err_o          = err_q;
    assign mem.valid      = mem_valid_q;
    assign mem.wr_rd      = mem_wr_rd_q;
    assign mem.addr       = mem_addr_q;
    assign mem.wr_data    = mem_wr_data_q;
endmodule
